// File: rtl/vga_sprite_slot_writer.sv
// Sprite slot bus initiator: streams a 2bpp bitmap from ROM into sprite RAM,
// programs bypass/x0/y0/ctrl, and commits game-logic updates on frame ticks.
module vga_sprite_slot_writer #(
    parameter int         ADDR_WIDTH = 10,
    parameter logic [10:0] X_INIT    = 11'd0,
    parameter logic [10:0] Y_INIT    = 11'd0,
    parameter logic [4:0]  CTRL_INIT = 5'b00100
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_start,
    input  logic                  bypass_in,
    input  logic                  frame_tick,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [10:0]           upd_x,
    input  logic [10:0]           upd_y,
    input  logic [4:0]            upd_ctrl,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [1:0]            rom_data,
    output logic                  cs,
    output logic                  write,
    output logic [13:0]           addr,
    output logic [31:0]           wr_data,
    output logic                  busy,
    output logic                  load_done
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, REG_BYP, REG_X, REG_Y, REG_CTRL, DONE
    } state_e;

    state_e                state_q, state_d;
    logic                  commit_q, commit_d;
    logic [CW-1:0]         idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [10:0]           px_q, px_d, py_q, py_d;
    logic [4:0]            pctrl_q, pctrl_d;
    logic                  pend_q, pend_d;
    logic [10:0]           wx_q, wx_d, wy_q, wy_d;
    logic [4:0]            wc_q, wc_d;
    logic                  cs_q, cs_d, ram_wr_q, ram_wr_d;
    logic [13:0]           addr_q, addr_d;
    logic [31:0]           wr_data_q, wr_data_d;
    logic                  busy_q, busy_d, done_q, done_d, ready_q, ready_d;
    logic                  accept;

    always_comb begin
        state_d    = state_q;
        commit_d   = commit_q;
        idx_d      = idx_q;
        rom_addr_d = rom_addr_q;
        px_d       = px_q;
        py_d       = py_q;
        pctrl_d    = pctrl_q;
        pend_d     = pend_q;
        wx_d       = wx_q;
        wy_d       = wy_q;
        wc_d       = wc_q;
        cs_d       = 1'b0;
        ram_wr_d   = 1'b0;
        addr_d     = addr_q;
        wr_data_d  = wr_data_q;
        accept     = (state_q == IDLE) && upd_valid;

        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d    = LOAD;
                    commit_d   = 1'b0;
                    idx_d      = '0;
                    rom_addr_d = '0;
                    wx_d       = accept ? upd_x : px_q;
                    wy_d       = accept ? upd_y : py_q;
                    wc_d       = accept ? upd_ctrl : pctrl_q;
                end else if (frame_tick && pend_q) begin
                    // Snapshot so a same-cycle accept waits for the next tick.
                    state_d  = REG_X;
                    commit_d = 1'b1;
                    wx_d     = px_q;
                    wy_d     = py_q;
                    wc_d     = pctrl_q;
                    pend_d   = 1'b0;
                end
            end
            LOAD: begin
                if (idx_q < CW'(DEPTH)) begin
                    cs_d     = 1'b1;
                    ram_wr_d = 1'b1;
                    addr_d   = 14'(idx_q[ADDR_WIDTH-1:0]);
                    idx_d    = idx_q + 1'b1;
                    if (idx_q < CW'(DEPTH - 1)) begin
                        rom_addr_d = rom_addr_q + 1'b1;
                    end
                end else begin
                    state_d = REG_BYP;
                end
            end
            REG_BYP:  state_d = REG_X;
            REG_X:    state_d = REG_Y;
            REG_Y:    state_d = REG_CTRL;
            REG_CTRL: state_d = commit_q ? IDLE : DONE;
            DONE: begin
                state_d = IDLE;
                pend_d  = 1'b0;
            end
            default:  state_d = IDLE;
        endcase

        if (accept) begin
            px_d    = upd_x;
            py_d    = upd_y;
            pctrl_d = upd_ctrl;
            pend_d  = 1'b1;
        end

        case (state_d)
            REG_BYP: begin
                cs_d      = 1'b1;
                addr_d    = 14'h2000;
                wr_data_d = {31'b0, bypass_in};
            end
            REG_X: begin
                cs_d      = 1'b1;
                addr_d    = 14'h2001;
                wr_data_d = {21'b0, wx_d};
            end
            REG_Y: begin
                cs_d      = 1'b1;
                addr_d    = 14'h2002;
                wr_data_d = {21'b0, wy_d};
            end
            REG_CTRL: begin
                cs_d      = 1'b1;
                addr_d    = 14'h2003;
                wr_data_d = {27'b0, wc_d};
            end
            default: ;
        endcase

        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            commit_q   <= 1'b0;
            idx_q      <= '0;
            rom_addr_q <= '0;
            px_q       <= X_INIT;
            py_q       <= Y_INIT;
            pctrl_q    <= CTRL_INIT;
            pend_q     <= 1'b0;
            wx_q       <= X_INIT;
            wy_q       <= Y_INIT;
            wc_q       <= CTRL_INIT;
            cs_q       <= 1'b0;
            ram_wr_q   <= 1'b0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            commit_q   <= commit_d;
            idx_q      <= idx_d;
            rom_addr_q <= rom_addr_d;
            px_q       <= px_d;
            py_q       <= py_d;
            pctrl_q    <= pctrl_d;
            pend_q     <= pend_d;
            wx_q       <= wx_d;
            wy_q       <= wy_d;
            wc_q       <= wc_d;
            cs_q       <= cs_d;
            ram_wr_q   <= ram_wr_d;
            addr_q     <= addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    // ROM output is itself registered; it lands in the cycle of its RAM write.
    assign wr_data   = ram_wr_q ? {30'b0, rom_data} : wr_data_q;
    assign cs        = cs_q;
    assign write     = cs_q;
    assign addr      = addr_q;
    assign rom_addr  = rom_addr_q;
    assign busy      = busy_q;
    assign load_done = done_q;
    assign upd_ready = ready_q;
endmodule
